// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter.
// The entry layout is fixed at the default data/address widths.
package wb_arbiter_pkg;

  localparam int WB_XLEN       = 64;
  localparam int WB_REG_AW     = 5;
  localparam int WB_FIFO_DEPTH = 4;

  // One buffered write-back request
  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic                 we;
    logic [WB_XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Generic DEPTH-entry FIFO of wb_entry_t with push/pop/clear.
// clear wins over push and pop, and resets both pointers.
module wb_result_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  input  logic          clear,
  output wb_entry_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges exe results (buffered) and load responses
// (never stalled, always win) onto the single register-file write port.
// The registered rf_* outputs are also the forwarding bundle back to exe.
// Optional macro WB_ARBITER_BYPASS_EN: an exe result arriving to an empty,
// idle FIFO is written directly, giving 1-cycle exe latency.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW,
  parameter int DEPTH  = WB_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exe_valid_i,
  output logic              exe_ready_o,
  input  logic [REG_AW-1:0] exe_rd_i,
  input  logic              exe_we_i,
  input  logic [XLEN-1:0]   exe_data_i,
  input  logic              mem_resp_valid_i,
  input  logic [REG_AW-1:0] mem_resp_rd_i,
  input  logic [XLEN-1:0]   mem_resp_data_i,
  input  logic              flush_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic [CW-1:0]     fifo_count_o,
  output logic [63:0]       commit_cnt_o
);

  wb_entry_t exe_entry;
  wb_entry_t mem_entry;
  wb_entry_t head;
  wb_entry_t sel;
  logic      sel_valid;
  logic      full;
  logic      empty;
  logic      accept;
  logic      bypass;
  logic      push;
  logic      pop;

  assign exe_entry = '{rd: exe_rd_i, we: exe_we_i, data: exe_data_i};
  assign mem_entry = '{rd: mem_resp_rd_i, we: 1'b1, data: mem_resp_data_i};

  // Ready comes from the registered count only, so a full FIFO refuses
  // even when it dequeues in the same cycle.
  assign exe_ready_o = !full;
  assign accept      = exe_valid_i && exe_ready_o && !flush_i;

`ifdef WB_ARBITER_BYPASS_EN
  assign bypass = accept && empty && !mem_resp_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;
  assign pop  = !mem_resp_valid_i && !empty && !flush_i;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .din   (exe_entry),
    .pop   (pop),
    .clear (flush_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );

  // Priority select: load response, then FIFO head, then bypassed exe
  always_comb begin
    sel       = mem_entry;
    sel_valid = 1'b0;
    if (mem_resp_valid_i) begin
      sel       = mem_entry;
      sel_valid = 1'b1;
    end else if (pop) begin
      sel       = head;
      sel_valid = 1'b1;
    end else if (bypass) begin
      sel       = exe_entry;
      sel_valid = 1'b1;
    end
  end

  // Registered write port and commit counter; x0 writes are committed but suppressed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      commit_cnt_o <= '0;
    end else begin
      rf_we_o <= sel_valid && sel.we && (sel.rd != '0);
      if (sel_valid) begin
        rf_waddr_o   <= sel.rd;
        rf_wdata_o   <= sel.data;
        commit_cnt_o <= commit_cnt_o + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (either build of WB_ARBITER_BYPASS_EN).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, exe_ready, exe_we;
  logic [4:0]  exe_rd;
  logic [63:0] exe_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [2:0]  fifo_count;
  logic [63:0] commit_cnt;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned exp_commit = 0;

  wb_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .exe_valid_i      (exe_valid),
    .exe_ready_o      (exe_ready),
    .exe_rd_i         (exe_rd),
    .exe_we_i         (exe_we),
    .exe_data_i       (exe_data),
    .mem_resp_valid_i (mem_valid),
    .mem_resp_rd_i    (mem_rd),
    .mem_resp_data_i  (mem_data),
    .flush_i          (flush),
    .rf_we_o          (rf_we),
    .rf_waddr_o       (rf_waddr),
    .rf_wdata_o       (rf_wdata),
    .fifo_count_o     (fifo_count),
    .commit_cnt_o     (commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exe_valid = 0; exe_we = 0; exe_rd = 0; exe_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; flush = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_waddr, 0);
    chk("rst_data", rf_wdata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_commit", commit_cnt, 0);
    chk("rst_ready", exe_ready, 1);

    // single exe result
    exe_valid = 1; exe_we = 1; exe_rd = 5; exe_data = 64'h2A;
    tick();
    idle();
`ifdef WB_ARBITER_BYPASS_EN
    chk("t1_bypass_count", fifo_count, 0);
`else
    chk("t1_stage_we", rf_we, 0);
    chk("t1_stage_count", fifo_count, 1);
    tick();
`endif
    exp_commit += 1;
    chk("t1_we", rf_we, 1);
    chk("t1_addr", rf_waddr, 5);
    chk("t1_data", rf_wdata, 64'h2A);
    chk("t1_commit", commit_cnt, exp_commit);
    tick();
    chk("t1_idle_we", rf_we, 0);
    chk("t1_hold_addr", rf_waddr, 5);

    // mem beats exe in the same cycle
    exe_valid = 1; exe_we = 1; exe_rd = 3; exe_data = 64'h11;
    mem_valid = 1; mem_rd = 7; mem_data = 64'h99;
    tick();
    idle();
    chk("t2_mem_we", rf_we, 1);
    chk("t2_mem_addr", rf_waddr, 7);
    chk("t2_mem_data", rf_wdata, 64'h99);
    chk("t2_count", fifo_count, 1);
    tick();
    exp_commit += 2;
    chk("t2_exe_we", rf_we, 1);
    chk("t2_exe_addr", rf_waddr, 3);
    chk("t2_exe_data", rf_wdata, 64'h11);
    chk("t2_commit", commit_cnt, exp_commit);
    tick();
    chk("t2_idle_we", rf_we, 0);

    // backpressure under continuous mem traffic, then in-order drain; 3 reps wrap pointers
    for (int rep = 0; rep < 3; rep++) begin
      for (int c = 0; c < 10; c++) begin
        mem_valid = 1; mem_rd = 0; mem_data = 64'(c);
        exe_valid = 1; exe_we = 1; exe_rd = 5'(10 + c); exe_data = 64'(rep * 100 + c);
        tick();
        chk("t3_fill_we", rf_we, 0);
        chk("t3_fill_count", fifo_count, (c + 1 < 4) ? 64'(c + 1) : 64'd4);
        chk("t3_ready", exe_ready, (c + 1 < 4) ? 64'd1 : 64'd0);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("t3_drain_we", rf_we, 1);
        chk("t3_drain_addr", rf_waddr, 64'(10 + i));
        chk("t3_drain_data", rf_wdata, 64'(rep * 100 + i));
      end
      tick();
      exp_commit += 14;
      chk("t3_empty_we", rf_we, 0);
      chk("t3_empty_count", fifo_count, 0);
      chk("t3_commit", commit_cnt, exp_commit);
    end

    // flush with 3 buffered entries and a concurrent load
    for (int c = 0; c < 3; c++) begin
      mem_valid = 1; mem_rd = 0; mem_data = 0;
      exe_valid = 1; exe_we = 1; exe_rd = 5'(20 + c); exe_data = 64'hDEAD0 + 64'(c);
      tick();
    end
    chk("t4_filled", fifo_count, 3);
    mem_valid = 1; mem_rd = 9; mem_data = 64'h1234;
    exe_valid = 1; exe_we = 1; exe_rd = 25; exe_data = 64'hBAD;
    flush = 1;
    tick();
    idle();
    exp_commit += 4;
    chk("t4_we", rf_we, 1);
    chk("t4_addr", rf_waddr, 9);
    chk("t4_data", rf_wdata, 64'h1234);
    chk("t4_count", fifo_count, 0);
    chk("t4_ready", exe_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_stale_we", rf_we, 0);
    end
    chk("t4_commit", commit_cnt, exp_commit);

    // x0 write suppressed but committed
    exe_valid = 1; exe_we = 1; exe_rd = 0; exe_data = 64'hFF;
    tick();
    idle();
    chk("t5_we_a", rf_we, 0);
`ifndef WB_ARBITER_BYPASS_EN
    tick();
    chk("t5_we_b", rf_we, 0);
`endif
    exp_commit += 1;
    chk("t5_data", rf_wdata, 64'hFF);
    chk("t5_commit", commit_cnt, exp_commit);
    tick();

    // reset while 2 entries are buffered
    for (int c = 0; c < 2; c++) begin
      mem_valid = 1; mem_rd = 0; mem_data = 0;
      exe_valid = 1; exe_we = 1; exe_rd = 5'(28 + c); exe_data = 64'h7700 + 64'(c);
      tick();
    end
    idle();
    chk("t6_filled", fifo_count, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_we", rf_we, 0);
    chk("t6_addr", rf_waddr, 0);
    chk("t6_data", rf_wdata, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_commit", commit_cnt, 0);
    chk("t6_ready", exe_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale_we", rf_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
